// File: rtl/clust_rst_seq_if.sv
// clust_rst_seq_if: debug-init, scan, acknowledge and sequenced reset outputs of the cluster reset receiver
interface clust_rst_seq_if;
  logic adbginit_l;
  logic se;
  logic rel_ack;
  logic cluster_rst_l;
  logic cluster_dbginit_l;
  logic rst_done;
  logic timeout_err;
  logic [2:0] rst_state;
  modport master (
    output adbginit_l, se, rel_ack,
    input  cluster_rst_l, cluster_dbginit_l, rst_done, timeout_err, rst_state
  );
  modport slave (
    input  adbginit_l, se, rel_ack,
    output cluster_rst_l, cluster_dbginit_l, rst_done, timeout_err, rst_state
  );
endinterface

// File: rtl/clust_rst_seq.sv
// clust_rst_seq: synchronizes cluster reset/debug-init release and sequences it with a ready handshake
module clust_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int DBG_DLY     = 4,
  parameter int RST_DLY     = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic rclk,
  input logic rst_l,
  clust_rst_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, DBG_WAIT = 3'd1, RST_WAIT = 3'd2, ACK_WAIT = 3'd3, DONE = 3'd4, ERR = 3'd5} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [SYNC_STAGES-1:0] rst_ff, dbg_ff;
  logic dbg_rst_n, rst_sync, dbg_sync, dbg_rel, dbginit, crst, done, err;
  assign dbg_rst_n = rst_l & bus.adbginit_l;
  assign rst_sync  = bus.se ? rst_l : rst_ff[SYNC_STAGES-1];
  assign dbg_sync  = bus.se ? dbg_rst_n : dbg_ff[SYNC_STAGES-1];
  assign dbg_rel   = state == DBG_WAIT && dbg_sync && cnt == CNT_W'(DBG_DLY - 1);
  always_ff @(posedge rclk or negedge rst_l)
    if (!rst_l) rst_ff <= '0;
    else rst_ff <= {rst_ff[SYNC_STAGES-2:0], 1'b1};
  always_ff @(posedge rclk or negedge dbg_rst_n)
    if (!dbg_rst_n) dbg_ff <= '0;
    else dbg_ff <= {dbg_ff[SYNC_STAGES-2:0], 1'b1};
  // debug init drops the moment adbginit_l falls, independent of the FSM
  always_ff @(posedge rclk or negedge dbg_rst_n)
    if (!dbg_rst_n) dbginit <= 1'b0;
    else if (dbg_rel) dbginit <= 1'b1;
  always_ff @(posedge rclk or negedge rst_l)
    if (!rst_l) begin
      state <= IDLE;
      cnt   <= '0;
      crst  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rst_sync) begin
          state <= DBG_WAIT;
          cnt   <= '0;
        end
        DBG_WAIT: if (!dbg_sync) cnt <= '0;
          else if (cnt == CNT_W'(DBG_DLY - 1)) begin
            state <= crst ? ACK_WAIT : RST_WAIT;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        RST_WAIT: if (!dbg_sync) begin
            state <= DBG_WAIT;
            cnt   <= '0;
          end else if (cnt == CNT_W'(RST_DLY - 1)) begin
            state <= ACK_WAIT;
            cnt   <= '0;
            crst  <= 1'b1;
          end else cnt <= cnt + 1'b1;
        ACK_WAIT: if (!dbg_sync) begin
            state <= DBG_WAIT;
            cnt   <= '0;
          end else if (bus.rel_ack) begin
            state <= DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state <= ERR;
            cnt   <= '0;
            err   <= 1'b1;
          end else cnt <= cnt + 1'b1;
        DONE: if (!dbg_sync) begin
          state <= DBG_WAIT;
          cnt   <= '0;
          done  <= 1'b0;
        end
        ERR: state <= ERR;
        default: state <= IDLE;
      endcase
    end
  assign bus.cluster_rst_l     = crst;
  assign bus.cluster_dbginit_l = dbginit;
  assign bus.rst_done          = done;
  assign bus.timeout_err       = err;
  assign bus.rst_state         = state;
endmodule

// File: tb/tb_clust_rst_seq.sv
// tb_clust_rst_seq: deadline-based reference model plus directed boot scenarios and randomized reset/debug/ack traffic
module tb_clust_rst_seq;
  localparam int S = 2, DD = 4, RD = 8, AT = 16;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int total = 0, bad = 0;
  clust_rst_seq_if bus();
  clust_rst_seq dut (.rclk(clk), .rst_l(rst_l), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction
  // model: phase follows the spec state numbering; timed phases release when
  // the edge index reaches entry edge + delay, sync ready after S clean edges
  int e = 0, rc = 0, dc = 0, ph = 0, t = 0;
  bit m_crst = 0, m_dbg = 0, m_done = 0, m_err = 0;
  always @(posedge clk) begin : model
    bit dlive, rs, ds;
    e++;
    if (!rst_l) begin
      rc = 0; dc = 0; ph = 0; t = 0;
      m_crst = 0; m_dbg = 0; m_done = 0; m_err = 0;
    end else begin
      dlive = bus.adbginit_l;
      if (!dlive) begin dc = 0; m_dbg = 0; end
      rs = bus.se ? 1'b1 : (rc >= S);
      ds = bus.se ? dlive : (dc >= S);
      case (ph)
        0: if (rs) begin ph = 1; t = e; end
        1: if (!ds) t = e;
           else if (e - t == DD) begin m_dbg = 1; ph = m_crst ? 3 : 2; t = e; end
        2: if (!ds) begin ph = 1; t = e; end
           else if (e - t == RD) begin m_crst = 1; ph = 3; t = e; end
        3: if (!ds) begin ph = 1; t = e; end
           else if (bus.rel_ack) begin ph = 4; m_done = 1; end
           else if (e - t == AT) begin ph = 5; m_err = 1; end
        4: if (!ds) begin ph = 1; t = e; m_done = 0; end
        default: ;
      endcase
      rc = rc < S ? rc + 1 : rc;
      dc = dlive ? (dc < S ? dc + 1 : dc) : 0;
    end
    #2;
    chk("state", bus.rst_state, ph);
    chk("cluster_rst_l", bus.cluster_rst_l, m_crst);
    chk("cluster_dbginit_l", bus.cluster_dbginit_l, m_dbg & rst_l & bus.adbginit_l);
    chk("rst_done", bus.rst_done, m_done);
    chk("timeout_err", bus.timeout_err, m_err);
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #3; end
  endtask
  task automatic boot();
    rst_l = 1'b0;
    tick(2);
    rst_l = 1'b1;
  endtask
  task automatic cold_checks();
    tick(2);  chk("c1 e2 state", bus.rst_state, 0);
    tick(1);  chk("c1 e3 state", bus.rst_state, 1);
    tick(3);  chk("c1 e6 dbginit", bus.cluster_dbginit_l, 0);
    tick(1);  chk("c1 e7 dbginit", bus.cluster_dbginit_l, 1);
    chk("c1 e7 state", bus.rst_state, 2);
    tick(7);  chk("c1 e14 crst", bus.cluster_rst_l, 0);
    tick(1);  chk("c1 e15 crst", bus.cluster_rst_l, 1);
    chk("c1 e15 state", bus.rst_state, 3);
    bus.rel_ack = 1'b1;
    tick(1);  chk("c1 e16 done", bus.rst_done, 1);
    chk("c1 e16 state", bus.rst_state, 4);
    bus.rel_ack = 1'b0;
  endtask
  initial begin
    int rlow, alow, ack_mod;
    bus.adbginit_l = 1'b1;
    bus.se = 1'b0;
    bus.rel_ack = 1'b0;
    tick(1);
    chk("reset state", bus.rst_state, 0);
    chk("reset crst", bus.cluster_rst_l, 0);
    chk("reset done", bus.rst_done, 0);
    boot();
    cold_checks();
    // warm init from DONE
    tick(2);
    bus.adbginit_l = 1'b0;
    #1;
    chk("w async dbginit", bus.cluster_dbginit_l, 0);
    tick(1);  chk("w done", bus.rst_done, 0);
    chk("w crst", bus.cluster_rst_l, 1);
    chk("w state", bus.rst_state, 1);
    tick(2);
    bus.adbginit_l = 1'b1;
    tick(5);  chk("w e8 dbginit", bus.cluster_dbginit_l, 0);
    tick(1);  chk("w e9 dbginit", bus.cluster_dbginit_l, 1);
    chk("w e9 state", bus.rst_state, 3);
    bus.rel_ack = 1'b1;
    tick(1);  chk("w ack state", bus.rst_state, 4);
    bus.rel_ack = 1'b0;
    // no ack: timeout, then ERR ignores ack
    boot();
    tick(30); chk("to e30 state", bus.rst_state, 3);
    tick(1);  chk("to e31 state", bus.rst_state, 5);
    chk("to e31 err", bus.timeout_err, 1);
    chk("to e31 done", bus.rst_done, 0);
    bus.rel_ack = 1'b1;
    tick(2);  chk("err hold", bus.rst_state, 5);
    bus.rel_ack = 1'b0;
    // ack on the timeout edge wins
    boot();
    tick(30);
    bus.rel_ack = 1'b1;
    tick(1);  chk("race state", bus.rst_state, 4);
    chk("race err", bus.timeout_err, 0);
    bus.rel_ack = 1'b0;
    // scan bypass
    rst_l = 1'b0;
    bus.se = 1'b1;
    tick(2);
    rst_l = 1'b1;
    tick(1);  chk("se e1 state", bus.rst_state, 1);
    tick(3);  chk("se e4 dbginit", bus.cluster_dbginit_l, 0);
    tick(1);  chk("se e5 dbginit", bus.cluster_dbginit_l, 1);
    tick(7);  chk("se e12 crst", bus.cluster_rst_l, 0);
    tick(1);  chk("se e13 crst", bus.cluster_rst_l, 1);
    bus.se = 1'b0;
    // reset mid-sequence, then identical cold boot
    boot();
    tick(10); chk("mid state", bus.rst_state, 2);
    rst_l = 1'b0;
    #1;
    chk("mid async state", bus.rst_state, 0);
    chk("mid async dbginit", bus.cluster_dbginit_l, 0);
    chk("mid async crst", bus.cluster_rst_l, 0);
    boot();
    cold_checks();
    // debug init held low through boot
    bus.adbginit_l = 1'b0;
    boot();
    tick(20); chk("stall state", bus.rst_state, 1);
    chk("stall dbginit", bus.cluster_dbginit_l, 0);
    chk("stall crst", bus.cluster_rst_l, 0);
    bus.adbginit_l = 1'b1;
    // randomized traffic
    rlow = 0; alow = 0; ack_mod = 8;
    for (int i = 0; i < 5000; i++) begin
      bus.rel_ack = ($urandom_range(0, ack_mod - 1) == 0);
      if (rlow > 0) begin
        rlow--;
        if (rlow == 0) rst_l = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_l = 1'b0;
        rlow = $urandom_range(1, 3);
        bus.se = ($urandom_range(0, 3) == 0);
        ack_mod = $urandom_range(2, 40);
      end
      if (alow > 0) begin
        alow--;
        if (alow == 0) bus.adbginit_l = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        bus.adbginit_l = 1'b0;
        alow = $urandom_range(1, 6);
      end
      tick(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
